spi_slave: RTL and testbench
============================

# spi_slave

SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the light8080 SOC IO space, clocked by the system clock. It oversamples an external master's `sck`/`ss_n`/`mosi`, shifts in received bytes, and shifts out bytes written by the CPU. It is the counterpart of the SOC's SPI master, so two boards can exchange bytes over the same wire protocol. It sits beside the UART; the CPU reaches it through the IO read and write registers at `SPI_TX_REG`/`SPI_RX_REG`.

## Interface
Parameters:
- `IDLE_BYTE`, default 8'hFF: byte shifted out when no CPU byte is pending.

Ports:
- `clock`  in  1  system clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock from master; asynchronous to `clock`.
- `ss_n`  in  1  slave select, active low; asynchronous.
- `mosi`  in  1  master-out data; asynchronous.
- `miso`  out  1  slave-out data; valid while `miso_oe`=1.
- `miso_oe`  out  1  output enable for the top-level tristate; equals synchronized `ss_n` low.
- `tx_byte`  in  8  byte for the next transfer.
- `tx_load`  in  1  one-cycle write strobe for `tx_byte`.
- `tx_full`  out  1  holding register occupied.
- `rx_byte`  out  8  last complete received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `rx_full`  out  1  unread byte present.
- `rx_rd`  in  1  one-cycle read strobe; clears `rx_full`.
- `rx_ovr`  out  1  sticky overrun flag; present only with `SPI_SLAVE_OVR_EN`.

## Operation
- Input conditioning:
  - Each of `sck`, `ss_n`, `mosi` passes a 2-FF synchronizer followed by one history FF.
  - Rising and falling edges are detected from the last two stages.
  - Synchronizer reset values: `sck`=0, `ss_n`=1, `mosi`=0.
- State machine states:
  - IDLE: synchronized `ss_n`=1.
  - ACTIVE: `ss_n`=0; `bit_cnt` runs 0..7.
- IDLE -> ACTIVE on `ss_n` falling edge:
  - `tx_sh` loads the holding register if `tx_full`, otherwise `IDLE_BYTE`.
  - `tx_full` clears when the holding register is consumed.
  - `bit_cnt`=0.
- In ACTIVE, on `sck` rising edge:
  - `rx_sh` <= {`rx_sh[6:0]`, `mosi`}.
  - `bit_cnt` increments.
- Byte completion (`bit_cnt`=7 at the rising edge):
  - `rx_byte` <= {`rx_sh[6:0]`, `mosi`}; `rx_valid`=1 for one cycle; `rx_full`=1.
  - `bit_cnt` wraps to 0.
  - `tx_sh` reloads as on entry (holding register or `IDLE_BYTE`).
- In ACTIVE, on `sck` falling edge:
  - `tx_sh` shifts left only if `bit_cnt`≠0.
  - The falling edge after a reload therefore does not disturb the new MSB.
- `miso` = `tx_sh[7]`; `miso_oe` = ~synchronized `ss_n`.
- ACTIVE -> IDLE on `ss_n` rising edge:
  - A partial byte is discarded: no `rx_valid`, `rx_byte` unchanged.
  - `bit_cnt` returns to 0.
  - The partially sent tx byte is lost; the holding register is untouched.
- TX handshake:
  - `tx_load` while `tx_full`=0 latches `tx_byte` and sets `tx_full`.
  - `tx_load` while `tx_full`=1 is ignored; the CPU must poll `tx_full`.
  - If `tx_load` and a reload fall in the same cycle, the reload uses the pre-cycle holding state (`IDLE_BYTE` if empty). The new byte lands in the holding register for the next byte.
- RX:
  - `rx_rd` clears `rx_full`.
  - If `rx_rd` coincides with byte completion, `rx_full` stays 1, because the new byte wins.
- Reset values:
  - `miso`=1 (`IDLE_BYTE` MSB), `miso_oe`=0.
  - `tx_full`=0, `rx_byte`=8'h00, `rx_valid`=0, `rx_full`=0, `rx_ovr`=0, `bit_cnt`=0.
- Reset mid-transfer aborts the byte. The block stays IDLE until a fresh `ss_n` falling edge is seen after the synchronizers refill.

## Timing
- Pin edge to internal edge detection: 3 `clock` cycles.
- `rx_valid` asserts 3–4 cycles after the 8th `sck` rising edge at the pin.
- `miso` changes 3–4 cycles after a `sck` falling pin edge.
- First `miso` bit is valid 3–4 cycles after `ss_n` falls. The master must wait at least 5 `clock` cycles from `ss_n` low to the first `sck` rise.
- `sck` high and low phases must each be ≥4 `clock` cycles, so f_sck ≤ f_clock/8.
- `tx_full` and `rx_full` update the cycle after their strobe or event.

## Configuration
- `SPI_SLAVE_OVR_EN` defined:
  - `rx_ovr` is set when a byte completes while `rx_full`=1.
  - `rx_ovr` is sticky and is cleared by `rx_rd`. If `rx_rd` and a new overrun coincide, set wins.
  - `rx_byte` is always overwritten by the newest byte.
- Not defined:
  - `rx_ovr` port is still present and tied to 0.
  - No overrun register is synthesized.

## Structure
- `spi_defs.vh` is the shared include, containing:
  - `SPI_TX_REG`/`SPI_RX_REG` (8'h90).
  - A status register address `SPI_STAT_REG` (8'h91), with bit layout {5'b0, `rx_ovr`, `rx_full`, `tx_full`}.
  - The default `IDLE_BYTE`.
- One sub-module, `spi_sync`: 2-FF synchronizer plus history FF with rise and fall outputs, instantiated three times.

## Test plan
- Reset, then `tx_load` 8'hA5 and transfer 8'h3C on `mosi`: `miso` stream = 10100101, `rx_byte`=8'h3C, one `rx_valid` pulse, `rx_full`=1, `tx_full`=0.
- No pending tx byte, two back-to-back bytes 8'h01, 8'h80 with `ss_n` held low: `miso` sends 8'hFF twice, with two `rx_valid` pulses carrying 8'h01 then 8'h80.
- `tx_load` 8'h11 then 8'h22 with no transfer in between: second load ignored, `tx_full` stays 1, next transfer sends 8'h11.
- `ss_n` deasserted after 5 bits: no `rx_valid`, `rx_byte` unchanged, `bit_cnt`=0. Next full transfer of 8'hC3 is received correctly.
- With `SPI_SLAVE_OVR_EN`, two bytes received without `rx_rd`: `rx_ovr`=1 and `rx_byte` holds the second byte. `rx_rd` then clears `rx_ovr` and `rx_full`. Without the macro, `rx_ovr` stays 0.
- `reset` pulsed during bit 3: all outputs return to reset values, `miso_oe`=0. A following transfer of 8'h5A is received correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the light8080 SOC SPI responder:
//   - IO register addresses used by the CPU to reach the block
//   - default byte shifted out when the CPU has nothing pending
//   - state encoding of the transfer state machine
//   - helper that packs the status register word
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    // IO space: data register (write = tx, read = rx) and status register
    localparam logic [7:0] SPI_TX_REG    = 8'h90;
    localparam logic [7:0] SPI_RX_REG    = 8'h90;
    localparam logic [7:0] SPI_STAT_REG  = 8'h91;

    // Byte sent when no CPU byte is waiting in the holding register
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Status register layout: {5'b0, rx_ovr, rx_full, tx_full}
    function automatic logic [7:0] spi_stat_word(input logic rx_ovr,
                                                 input logic rx_full,
                                                 input logic tx_full);
        return {5'b0, rx_ovr, rx_full, tx_full};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// Brings one asynchronous SPI pin into the clock domain: two synchronizer
// flops followed by one history flop, with edge detection between the last
// two stages.
//   clock  in   system clock
//   reset  in   synchronous active-high reset (all stages load RST_VAL)
//   din    in   asynchronous pin
//   q      out  synchronized level
//   rise   out  one-cycle pulse, synchronized 0->1
//   fall   out  one-cycle pulse, synchronized 1->0
// ---------------------------------------------------------------------------
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    // sh_reg[0], sh_reg[1]: synchronizer; sh_reg[2]: history
    logic [2:0] sh_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_reg <= {3{RST_VAL}};
        end else begin
            sh_reg <= {sh_reg[1:0], din};
        end
    end

    assign q    = sh_reg[1];
    assign rise =  sh_reg[1] & ~sh_reg[2];
    assign fall = ~sh_reg[1] &  sh_reg[2];

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode 0 (CPOL=0, CPHA=0, MSB first) responder for the light8080 SOC,
// oversampling sck/ss_n/mosi with the system clock.
//   clock, reset      system clock, synchronous active-high reset
//   sck, ss_n, mosi   asynchronous SPI pins from the master
//   miso, miso_oe     slave data and tristate enable (oe = ss_n low, synced)
//   tx_byte, tx_load  CPU write into the tx holding register
//   tx_full           holding register occupied
//   rx_byte, rx_valid last received byte, one-cycle update pulse
//   rx_full, rx_rd    unread-byte flag and its clearing read strobe
//   rx_ovr            sticky overrun flag (tied 0 unless enabled)
// Build option: define SPI_SLAVE_OVR_EN to implement the overrun flag.
// ---------------------------------------------------------------------------
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       tx_full,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_full,
    input  logic       rx_rd,
    output logic       rx_ovr
);

    // Pin order in the synchronizer vectors: {mosi, ss_n, sck}
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] pin_vec;
    logic [2:0] sync_q;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign pin_vec = {mosi, ss_n, sck};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync #(
                .RST_VAL(SYNC_RST[gi])
            ) u_sync (
                .clock(clock),
                .reset(reset),
                .din  (pin_vec[gi]),
                .q    (sync_q[gi]),
                .rise (sync_rise[gi]),
                .fall (sync_fall[gi])
            );
        end
    endgenerate

    logic sck_rise, sck_fall, ss_rise, ss_fall, ss_q, mosi_q;
    assign sck_rise = sync_rise[0];
    assign sck_fall = sync_fall[0];
    assign ss_q     = sync_q[1];
    assign ss_rise  = sync_rise[1];
    assign ss_fall  = sync_fall[1];
    assign mosi_q   = sync_q[2];

    logic [2:0] unused_edges;
    assign unused_edges = {sync_q[0], sync_rise[2], sync_fall[2]};

    spi_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] tx_sh_reg, tx_sh_next;
    logic [7:0] hold_reg, hold_next;
    logic       tx_full_reg, tx_full_next;
    logic [7:0] rx_sh_reg, rx_sh_next;
    logic [7:0] rx_byte_reg, rx_byte_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       rx_full_reg, rx_full_next;
    logic       reload;
    logic       byte_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            tx_sh_reg    <= IDLE_BYTE;
            hold_reg     <= 8'h00;
            tx_full_reg  <= 1'b0;
            rx_sh_reg    <= 8'h00;
            rx_byte_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            rx_full_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_sh_reg    <= tx_sh_next;
            hold_reg     <= hold_next;
            tx_full_reg  <= tx_full_next;
            rx_sh_reg    <= rx_sh_next;
            rx_byte_reg  <= rx_byte_next;
            rx_valid_reg <= rx_valid_next;
            rx_full_reg  <= rx_full_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_sh_next    = tx_sh_reg;
        rx_sh_next    = rx_sh_reg;
        rx_byte_next  = rx_byte_reg;
        rx_valid_next = 1'b0;
        rx_full_next  = rx_full_reg & ~rx_rd;
        reload        = 1'b0;
        byte_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next   = ST_ACTIVE;
                    bit_cnt_next = 3'd0;
                    reload       = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    // Abort: partial rx byte dropped, rx_byte untouched
                    state_next   = ST_IDLE;
                    bit_cnt_next = 3'd0;
                end else if (sck_rise) begin
                    rx_sh_next   = {rx_sh_reg[6:0], mosi_q};
                    bit_cnt_next = bit_cnt_reg + 3'd1;   // 7 wraps to 0
                    if (bit_cnt_reg == 3'd7) begin
                        byte_done     = 1'b1;
                        rx_byte_next  = {rx_sh_reg[6:0], mosi_q};
                        rx_valid_next = 1'b1;
                        rx_full_next  = 1'b1;   // new byte beats a same-cycle read
                        reload        = 1'b1;
                    end
                end else if (sck_fall && bit_cnt_reg != 3'd0) begin
                    // No shift at bit_cnt 0 so a freshly loaded MSB survives
                    tx_sh_next = {tx_sh_reg[6:0], 1'b1};
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Reload always sees the pre-cycle holding state
        if (reload) begin
            tx_sh_next = tx_full_reg ? hold_reg : IDLE_BYTE;
        end
    end

    // Holding register: a full register consumes on reload and ignores loads;
    // an empty one accepts a load even when a reload happens the same cycle.
    assign tx_full_next = tx_full_reg ? ~reload : tx_load;
    assign hold_next    = (!tx_full_reg && tx_load) ? tx_byte : hold_reg;

`ifdef SPI_SLAVE_OVR_EN
    logic rx_ovr_reg, rx_ovr_next;

    always_comb begin
        rx_ovr_next = rx_ovr_reg;
        if (byte_done && rx_full_reg) begin
            rx_ovr_next = 1'b1;             // set beats a same-cycle clear
        end else if (rx_rd) begin
            rx_ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_ovr_reg <= 1'b0;
        end else begin
            rx_ovr_reg <= rx_ovr_next;
        end
    end

    assign rx_ovr = rx_ovr_reg;
`else
    logic unused_byte_done;
    assign unused_byte_done = byte_done;
    assign rx_ovr = 1'b0;
`endif

    assign miso     = tx_sh_reg[7];
    assign miso_oe  = ~ss_q;
    assign tx_full  = tx_full_reg;
    assign rx_byte  = rx_byte_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_full  = rx_full_reg;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Drives spi_slave as an SPI mode 0 master (sck phases of 6 clocks) and
// compares against a byte-level model: the tx byte of each slot is the
// pending CPU byte or 8'hFF, every completed byte lands in rx_byte, and the
// rx_full / tx_full / rx_ovr flags follow the CPU strobes and byte events.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       sck     = 1'b0;
    logic       ss_n    = 1'b1;
    logic       mosi    = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_load = 1'b0;
    logic       rx_rd   = 1'b0;
    logic       miso, miso_oe, tx_full, rx_valid, rx_full, rx_ovr;
    logic [7:0] rx_byte;

    always #5 clock = ~clock;

    spi_slave dut (
        .clock   (clock),
        .reset   (reset),
        .sck     (sck),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .tx_byte (tx_byte),
        .tx_load (tx_load),
        .tx_full (tx_full),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_full (rx_full),
        .rx_rd   (rx_rd),
        .rx_ovr  (rx_ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit         m_pend;
    logic [7:0] m_hold;
    bit         m_rx_full;
    bit         m_ovr;
    logic [7:0] m_last;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] mo_buf[4];

    always @(negedge clock) begin
        if (rx_valid) obs_q.push_back(rx_byte);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic exp_ovr();
`ifdef SPI_SLAVE_OVR_EN
        return m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] take_tx();
        logic [7:0] b;
        b = m_pend ? m_hold : 8'hFF;
        m_pend = 0;
        return b;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_hold = 8'h00; m_rx_full = 0; m_ovr = 0; m_last = 8'h00;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic cpu_load(input logic [7:0] b);
        if (!m_pend) begin
            m_pend = 1;
            m_hold = b;
        end
        tx_byte = b; tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
        check("tx_full_after_load", tx_full, 1'b1);
    endtask

    task automatic cpu_read();
        m_rx_full = 0;
        m_ovr = 0;
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
        tick(1);
        check("rx_full_after_rd", rx_full, 1'b0);
        check("rx_ovr_after_rd", rx_ovr, 1'b0);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(6);
            mi[7-i] = miso;
            sck = 1'b1;
            tick(6);
            sck = 1'b0;
        end
    endtask

    // One ss_n-low session of nbytes; the last byte is cut after last_bits.
    task automatic run_session(input int nbytes, input int last_bits);
        logic [7:0] mi, exp_tx;
        int nb, nobs;
        bit full;
        ss_n = 1'b0;
        exp_tx = take_tx();
        tick(8);
        check("miso_oe_active", miso_oe, 1'b1);
        for (int b = 0; b < nbytes; b++) begin
            full = (b < nbytes - 1) || (last_bits == 8);
            nb = full ? 8 : last_bits;
            xfer(mo_buf[b], nb, mi);
            if (full) begin
                check("miso_byte", mi, exp_tx);
                if (m_rx_full) m_ovr = 1;
                m_rx_full = 1;
                m_last = mo_buf[b];
                exp_q.push_back(mo_buf[b]);
                $display("[TB] byte mosi=%02h miso=%02h (expected %02h)", mo_buf[b], mi, exp_tx);
                exp_tx = take_tx();
            end else begin
                $display("[TB] partial byte mosi=%02h cut after %0d bits", mo_buf[b], nb);
            end
        end
        ss_n = 1'b1;
        tick(8);
        nobs = obs_q.size();
        check("rx_valid_count", nobs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nobs; i++)
            check("rx_valid_byte", obs_q[i], exp_q[i]);
        exp_q.delete();
        obs_q.delete();
        check("rx_byte", rx_byte, m_last);
        check("rx_full", rx_full, m_rx_full);
        check("tx_full", tx_full, m_pend);
        check("rx_ovr", rx_ovr, exp_ovr());
        check("miso_oe_idle", miso_oe, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", miso, 1'b1);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_full", rx_full, 1'b0);
        check("rst_rx_ovr", rx_ovr, 1'b0);
    endtask

    initial begin
        logic [7:0] mi;
        model_reset();
        tick(4);
        check_reset_outputs();
        reset = 1'b0;
        tick(4);
        check_reset_outputs();

        // A5 out, 3C in
        cpu_load(8'hA5);
        mo_buf[0] = 8'h3C;
        run_session(1, 8);

        // Back-to-back with nothing pending: FF, FF out; 01, 80 in
        cpu_read();
        mo_buf[0] = 8'h01; mo_buf[1] = 8'h80;
        run_session(2, 8);

        // Second load ignored while full
        cpu_read();
        cpu_load(8'h11);
        cpu_load(8'h22);
        mo_buf[0] = 8'h66;
        run_session(1, 8);

        // Abort after 5 bits, then C3
        mo_buf[0] = 8'hE7;
        run_session(1, 5);
        check("bit_cnt_after_abort", dut.bit_cnt_reg, 3'd0);
        mo_buf[0] = 8'hC3;
        run_session(1, 8);

        // Overrun: two unread bytes, then read
        cpu_read();
        mo_buf[0] = 8'h12; mo_buf[1] = 8'h34;
        run_session(2, 8);
        cpu_read();

        // Reset during bit 3
        cpu_load(8'h77);
        ss_n = 1'b0;
        tick(8);
        xfer(8'hFF, 3, mi);
        tick(2);
        reset = 1'b1;
        tick(3);
        check_reset_outputs();
        ss_n = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(8);
        check_reset_outputs();
        $display("[TB] reset pulsed mid-transfer");
        mo_buf[0] = 8'h5A;
        run_session(1, 8);

        // Randomized sessions
        for (int it = 0; it < 25; it++) begin
            int nbytes, last_bits;
            if ($urandom_range(0, 1) == 1) cpu_load(8'($urandom));
            if ($urandom_range(0, 2) == 0) cpu_read();
            nbytes = $urandom_range(1, 3);
            last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int b = 0; b < 4; b++) mo_buf[b] = 8'($urandom);
            run_session(nbytes, last_bits);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
